imem_loader: RTL
================

# imem_loader

Hardware program loader for the single-cycle processor: the writer side of the instruction-memory interface, which the core only reads. It accepts a byte stream on a valid/ready port and packs the bytes little-endian into 32-bit words. Each word is written sequentially into instruction memory from word address 0. The core is held in reset until the programmed number of words has landed, which removes the need for a simulation-only memory preload and lets the same image be loaded on silicon/FPGA.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; DEPTH = 2**ADDR_WIDTH words.
- `TIMEOUT`, default 1024: maximum idle cycles allowed between accepted bytes while receiving.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a load; sampled only in IDLE, DONE or ERR.
- `word_count`  in  ADDR_WIDTH+1: number of words to load; sampled with `start`.
- `s_valid`  in  1: byte available.
- `s_data`  in  8: byte payload.
- `s_ready`  out  1: loader accepts a byte this cycle.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH: word address of the write.
- `imem_wdata`  out  32: packed word.
- `core_rst`  out  1: reset to the processor; high except in DONE.
- `busy`  out  1: high in RECV or WRITE.
- `done`  out  1: high in DONE.
- `err`  out  1: high in ERR.

## Operation
- **States:** IDLE, RECV, WRITE, DONE, ERR. Reset state is IDLE.
- **IDLE/DONE/ERR + `start`:**
  - Latch `word_count` into `count_q`; clear the word index and byte index.
  - `count_q == 0` → DONE.
  - `count_q > DEPTH` → ERR.
  - Otherwise → RECV.
- **`start` in RECV/WRITE:** ignored.
- **RECV:**
  - `s_ready` = 1.
  - A handshake (`s_valid && s_ready`) shifts `s_data` into byte lane `byte_idx`; byte 0 goes to bits [7:0].
  - On the 4th byte → WRITE.
- **WRITE:**
  - `imem_we` = 1, `imem_addr` = `word_idx`, `imem_wdata` = packed word; `s_ready` = 0.
  - Next cycle: if `word_idx + 1 == count_q` → DONE; else increment `word_idx` and return to RECV.
- **Timeout:** the idle counter clears on entering RECV and on every accepted byte. When it reaches TIMEOUT-1 in RECV with no byte → ERR, and the partial word is discarded (never written).
- **DONE:** `core_rst` = 0, so the core runs. A new `start` re-asserts `core_rst` on the next cycle.
- **ERR:** `core_rst` stays 1 until a successful reload.
- **Address wrap:** none is possible. `count_q <= DEPTH` guarantees `word_idx` never exceeds DEPTH-1.

## Timing
- **Reset values:**
  - `s_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `core_rst` = 1, `busy` = 0, `done` = 0, `err` = 0.
  - All counters = 0.
- **Outputs:** all outputs are registered or decoded from the state register; there is no combinational path from `s_valid` to `s_ready`.
- **Start latency:** `start` at cycle N → state at N+1 (`s_ready` = 1 in RECV at N+1).
- **Throughput:** 4 byte cycles plus 1 WRITE cycle per word, i.e. 5 cycles per word minimum with `s_valid` held high.
- **Last word:** `imem_we` pulses in the cycle after the 4th byte of the last word. `core_rst` falls and `done` rises one cycle after that pulse.
- **Stalls:** `s_valid` low stalls RECV indefinitely below TIMEOUT; no byte is lost or duplicated.
- **`rst` mid-load:** immediate return to IDLE with `core_rst` = 1. Words already written stay in memory; no further write is issued.

## Structure
- **Package `loader_pkg`:** state enum `loader_state_e` and localparam `BYTES_PER_WORD = 4`. `ADDR_WIDTH` is shared with the imem module parameter.
- **Sub-module `byte_packer`:** 32-bit shift/lane register plus 2-bit byte index. Inputs are `load`, `clear` and `byte_in`; outputs are `word` and `full`.
- **Top level:** contains the FSM, word index, `count_q` and the timeout counter.
- **Integration:** the processor top muxes imem write access to the loader; the core never writes imem.

## Test plan
- **Two-word load:** `word_count` = 2; bytes 0x13,0x05,0x50,0x00,0xB3,0x05,0xB5,0x00 → writes 0x00500513 @0, then 0x00B505B3 @1; `core_rst` falls exactly 1 cycle after the second `imem_we`; `done` = 1.
- **Zero / oversize count:**
  - `word_count` = 0 → DONE the next cycle with no `imem_we`.
  - `word_count` = 257 (ADDR_WIDTH = 8) → ERR with `core_rst` = 1.
- **Backpressure/gaps:** random `s_valid` gaps under TIMEOUT over 16 words → every word is correct, addresses run 0..15, and there are no duplicate writes.
- **Timeout:** 2 bytes, then silence for TIMEOUT cycles → ERR with no `imem_we`. A new `start` plus a clean 1-word load → DONE.
- **Reset mid-load:** `rst` asserted after word 3 → IDLE with all outputs at reset values. A reload of 4 words completes correctly.
- **Full depth and restart:** `word_count` = 256 → last write at `imem_addr` 255, then DONE. `start` while in DONE re-asserts `core_rst` on the next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory program loader.
package loader_pkg;

  localparam int BYTES_PER_WORD  = 4;
  localparam int IMEM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: byte 0 lands in bits [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q[8*idx_q +: 8] <= byte_in;
      idx_q                <= idx_q + 2'd1;
    end
  end

  // High when the byte being loaded completes the word.
  assign full = load && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory and holds the core in reset until done.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [TW-1:0]         idle_q, idle_d;

  logic        pk_load;
  logic        pk_clear;
  logic        pk_full;
  logic [31:0] pk_word;
  logic        last;

  assign pk_load = s_valid && (state_q == RECV);
  assign last    = ({1'b0, widx_q} + (ADDR_WIDTH+1)'(1)) == count_q;

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .load    (pk_load),
    .clear   (pk_clear),
    .byte_in (s_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      widx_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    widx_d   = widx_q;
    idle_d   = idle_q;
    pk_clear = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          count_d  = word_count;
          widx_d   = '0;
          idle_d   = '0;
          pk_clear = 1'b1;
          if (word_count == '0)
            state_d = DONE;
          else if (word_count > DEPTH)
            state_d = ERR;
          else
            state_d = RECV;
        end
      end
      RECV: begin
        if (pk_load) begin
          idle_d = '0;
          if (pk_full)
            state_d = WRITE;
        end else if (idle_q == TMAX) begin
          // Drop the partial word so it can never be written.
          state_d  = ERR;
          idle_d   = '0;
          pk_clear = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      WRITE: begin
        idle_d = '0;
        if (last) begin
          state_d = DONE;
        end else begin
          widx_d  = widx_q + ADDR_WIDTH'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready    = (state_q == RECV);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = widx_q;
  assign imem_wdata = pk_word;
  assign core_rst   = (state_q != DONE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);

endmodule
